// File: rtl/regfile_pkg.sv
// Shared encodings, flag constants and block-engine types for the banked register file.
package regfile_pkg;

  typedef logic [3:0] reg_select;

  localparam reg_select REG_A  = 4'd0;
  localparam reg_select REG_B  = 4'd1;
  localparam reg_select REG_C  = 4'd2;
  localparam reg_select REG_D  = 4'd3;
  localparam reg_select REG_E  = 4'd4;
  localparam reg_select REG_H  = 4'd5;
  localparam reg_select REG_L  = 4'd6;
  localparam reg_select REG_BC = 4'd7;
  localparam reg_select REG_DE = 4'd8;
  localparam reg_select REG_HL = 4'd9;
  localparam reg_select REG_IX = 4'd10;
  localparam reg_select REG_IY = 4'd11;
  localparam reg_select REG_SP = 4'd12;

  localparam reg_select REG_FIRST16 = REG_BC;
  localparam reg_select REG_LAST16  = REG_SP;

  localparam int unsigned FLAG_C  = 0;
  localparam int unsigned FLAG_N  = 1;
  localparam int unsigned FLAG_PV = 2;
  localparam int unsigned FLAG_3  = 3;
  localparam int unsigned FLAG_H  = 4;
  localparam int unsigned FLAG_5  = 5;
  localparam int unsigned FLAG_Z  = 6;
  localparam int unsigned FLAG_S  = 7;

  localparam logic [7:0] FLAG_PV_MASK = 8'h04;
  // Flags cleared by every block-transfer iteration: H, N, PV.
  localparam logic [7:0] BLK_CLR_MASK = 8'h16;

  typedef logic [1:0] blk_state_t;
  localparam blk_state_t IDLE   = 2'd0;
  localparam blk_state_t ACTIVE = 2'd1;
  localparam blk_state_t DONE   = 2'd2;

  typedef struct packed {
    logic dir;
    logic rep;
  } blk_cfg_t;

  function automatic logic is_8bit(reg_select s);
    return s <= REG_L;
  endfunction

  function automatic logic is_16bit(reg_select s);
    return (s >= REG_FIRST16) && (s <= REG_LAST16);
  endfunction

endpackage

// File: rtl/regfile_rd_mux.sv
// Per-port read selector over the current-bank registers, with optional same-cycle write bypass.
module regfile_rd_mux
  import regfile_pkg::*;
(
  input  reg_select   sel_i,
  input  logic [7:0]  a_i,
  input  logic [15:0] bc_i,
  input  logic [15:0] de_i,
  input  logic [15:0] hl_i,
  input  logic [15:0] ix_i,
  input  logic [15:0] iy_i,
  input  logic [15:0] sp_i,
  input  logic        byp_en_i,
  input  reg_select   byp_sel_i,
  input  logic [15:0] byp_data_i,
  output logic [15:0] rd_data_o
);

  logic [15:0] stored;

  always_comb begin
    stored = '0;
    case (sel_i)
      REG_A:   stored = {8'h00, a_i};
      REG_B:   stored = {8'h00, bc_i[15:8]};
      REG_C:   stored = {8'h00, bc_i[7:0]};
      REG_D:   stored = {8'h00, de_i[15:8]};
      REG_E:   stored = {8'h00, de_i[7:0]};
      REG_H:   stored = {8'h00, hl_i[15:8]};
      REG_L:   stored = {8'h00, hl_i[7:0]};
      REG_BC:  stored = bc_i;
      REG_DE:  stored = de_i;
      REG_HL:  stored = hl_i;
      REG_IX:  stored = ix_i;
      REG_IY:  stored = iy_i;
      REG_SP:  stored = sp_i;
      default: stored = '0;
    endcase
  end

  // A byte write into a pair being read replaces only that byte; the other comes from storage.
  always_comb begin
    rd_data_o = stored;
    if (byp_en_i) begin
      if ((byp_sel_i == sel_i) && is_8bit(sel_i)) begin
        rd_data_o = {8'h00, byp_data_i[7:0]};
      end else if ((byp_sel_i == sel_i) && is_16bit(sel_i)) begin
        rd_data_o = byp_data_i;
      end else begin
        case ({byp_sel_i, sel_i})
          {REG_B, REG_BC}: rd_data_o = {byp_data_i[7:0], stored[7:0]};
          {REG_C, REG_BC}: rd_data_o = {stored[15:8], byp_data_i[7:0]};
          {REG_D, REG_DE}: rd_data_o = {byp_data_i[7:0], stored[7:0]};
          {REG_E, REG_DE}: rd_data_o = {stored[15:8], byp_data_i[7:0]};
          {REG_H, REG_HL}: rd_data_o = {byp_data_i[7:0], stored[7:0]};
          {REG_L, REG_HL}: rd_data_o = {stored[15:8], byp_data_i[7:0]};
          default:         rd_data_o = stored;
        endcase
      end
    end
  end

endmodule

// File: rtl/banked_regfile.sv
// Banked Z80-style register file with exchange support and a block-transfer engine.
// Optional macro RD_BYPASS_EN forwards accepted writes to read ports and f_out in the same cycle.
module banked_regfile
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_READ  = 2,
  parameter int unsigned NUM_BANKS = 2,
  localparam int unsigned BANK_W   = $clog2(NUM_BANKS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en_i,
  input  reg_select                 wr_sel_i,
  input  logic [15:0]               wr_data_i,
  input  reg_select [NUM_READ-1:0]  rd_sel_i,
  output logic [NUM_READ-1:0][15:0] rd_data_o,
  output logic [7:0]                f_out_o,
  input  logic [7:0]                f_in_i,
  input  logic                      f_wr_i,
  input  logic                      ex_af_i,
  input  logic                      exx_i,
  input  logic                      ex_de_hl_i,
  input  logic                      blk_start_i,
  input  logic                      blk_dir_i,
  input  logic                      blk_repeat_i,
  input  logic                      blk_step_i,
  output logic                      blk_busy_o,
  output logic                      blk_done_o,
  output logic [BANK_W-1:0]         af_bank_o,
  output logic [BANK_W-1:0]         main_bank_o
);

  logic [7:0]  a_q  [NUM_BANKS];
  logic [7:0]  a_d  [NUM_BANKS];
  logic [7:0]  f_q  [NUM_BANKS];
  logic [7:0]  f_d  [NUM_BANKS];
  logic [15:0] bc_q [NUM_BANKS];
  logic [15:0] bc_d [NUM_BANKS];
  logic [15:0] de_q [NUM_BANKS];
  logic [15:0] de_d [NUM_BANKS];
  logic [15:0] hl_q [NUM_BANKS];
  logic [15:0] hl_d [NUM_BANKS];
  logic [15:0] ix_q, ix_d, iy_q, iy_d, sp_q, sp_d;
  logic [BANK_W-1:0] af_bank_q, af_bank_d, main_bank_q, main_bank_d;
  blk_state_t state_q, state_d;
  blk_cfg_t   cfg_q, cfg_d;

  logic        idle;
  logic        wr_accept;
  logic        f_accept;
  logic        byp_en;
  logic [7:0]  a_cur, f_cur;
  logic [15:0] bc_cur, de_cur, hl_cur, bc_dec, swap_tmp;

  assign idle      = (state_q == IDLE);
  assign wr_accept = wr_en_i & idle;
  assign f_accept  = f_wr_i & idle;
  assign a_cur     = a_q[af_bank_q];
  assign f_cur     = f_q[af_bank_q];
  assign bc_cur    = bc_q[main_bank_q];
  assign de_cur    = de_q[main_bank_q];
  assign hl_cur    = hl_q[main_bank_q];
  assign bc_dec    = bc_cur - 16'd1;

  always_comb begin
    a_d         = a_q;
    f_d         = f_q;
    bc_d        = bc_q;
    de_d        = de_q;
    hl_d        = hl_q;
    ix_d        = ix_q;
    iy_d        = iy_q;
    sp_d        = sp_q;
    af_bank_d   = af_bank_q;
    main_bank_d = main_bank_q;
    state_d     = state_q;
    cfg_d       = cfg_q;
    swap_tmp    = '0;
    case (state_q)
      IDLE: begin
        // Writes resolve against the old mapping, then the swap, then the pointer advance.
        if (wr_accept) begin
          case (wr_sel_i)
            REG_A:   a_d[af_bank_q]          = wr_data_i[7:0];
            REG_B:   bc_d[main_bank_q][15:8] = wr_data_i[7:0];
            REG_C:   bc_d[main_bank_q][7:0]  = wr_data_i[7:0];
            REG_D:   de_d[main_bank_q][15:8] = wr_data_i[7:0];
            REG_E:   de_d[main_bank_q][7:0]  = wr_data_i[7:0];
            REG_H:   hl_d[main_bank_q][15:8] = wr_data_i[7:0];
            REG_L:   hl_d[main_bank_q][7:0]  = wr_data_i[7:0];
            REG_BC:  bc_d[main_bank_q]       = wr_data_i;
            REG_DE:  de_d[main_bank_q]       = wr_data_i;
            REG_HL:  hl_d[main_bank_q]       = wr_data_i;
            REG_IX:  ix_d                    = wr_data_i;
            REG_IY:  iy_d                    = wr_data_i;
            REG_SP:  sp_d                    = wr_data_i;
            default: ;
          endcase
        end
        if (f_accept) f_d[af_bank_q] = f_in_i;
        if (ex_de_hl_i) begin
          swap_tmp          = de_d[main_bank_q];
          de_d[main_bank_q] = hl_d[main_bank_q];
          hl_d[main_bank_q] = swap_tmp;
        end
        if (ex_af_i) af_bank_d = af_bank_q + BANK_W'(1);
        if (exx_i) main_bank_d = main_bank_q + BANK_W'(1);
        if (blk_start_i) begin
          state_d   = ACTIVE;
          cfg_d.dir = blk_dir_i;
          cfg_d.rep = blk_repeat_i;
        end
      end
      ACTIVE: begin
        if (blk_step_i) begin
          bc_d[main_bank_q] = bc_dec;
          de_d[main_bank_q] = cfg_q.dir ? (de_cur - 16'd1) : (de_cur + 16'd1);
          hl_d[main_bank_q] = cfg_q.dir ? (hl_cur - 16'd1) : (hl_cur + 16'd1);
          f_d[af_bank_q]    = (f_cur & ~BLK_CLR_MASK) |
                              ((bc_dec != 16'd0) ? FLAG_PV_MASK : 8'h00);
          if (!cfg_q.rep || (bc_dec == 16'd0)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < int'(NUM_BANKS); b++) begin
        a_q[b]  <= '0;
        f_q[b]  <= '0;
        bc_q[b] <= '0;
        de_q[b] <= '0;
        hl_q[b] <= '0;
      end
      ix_q        <= '0;
      iy_q        <= '0;
      sp_q        <= '0;
      af_bank_q   <= '0;
      main_bank_q <= '0;
      state_q     <= IDLE;
      cfg_q       <= '0;
    end else begin
      a_q         <= a_d;
      f_q         <= f_d;
      bc_q        <= bc_d;
      de_q        <= de_d;
      hl_q        <= hl_d;
      ix_q        <= ix_d;
      iy_q        <= iy_d;
      sp_q        <= sp_d;
      af_bank_q   <= af_bank_d;
      main_bank_q <= main_bank_d;
      state_q     <= state_d;
      cfg_q       <= cfg_d;
    end
  end

`ifdef RD_BYPASS_EN
  assign byp_en  = wr_accept;
  assign f_out_o = f_accept ? f_in_i : f_cur;
`else
  assign byp_en  = 1'b0;
  assign f_out_o = f_cur;
`endif

  for (genvar p = 0; p < int'(NUM_READ); p++) begin : g_rd
    regfile_rd_mux u_rd_mux (
      .sel_i      (rd_sel_i[p]),
      .a_i        (a_cur),
      .bc_i       (bc_cur),
      .de_i       (de_cur),
      .hl_i       (hl_cur),
      .ix_i       (ix_q),
      .iy_i       (iy_q),
      .sp_i       (sp_q),
      .byp_en_i   (byp_en),
      .byp_sel_i  (wr_sel_i),
      .byp_data_i (wr_data_i),
      .rd_data_o  (rd_data_o[p])
    );
  end

  assign blk_busy_o  = (state_q == ACTIVE) || (state_q == DONE);
  assign blk_done_o  = (state_q == DONE);
  assign af_bank_o   = af_bank_q;
  assign main_bank_o = main_bank_q;

endmodule
